// File: rtl/syn_rcv.sv
// Frame-sync receiver: acquires, flywheels and monitors a periodic 1-cycle sync pulse.
// Latency: isyn sampled at cycle t is reflected on every output at t+1; oerrcnt counts one cycle after oerr.
// Backpressure: none; free-running on every iclk38 edge, no flow control on any port.
//
// Ports:
//   iclk38  - single clock, rising edge
//   rst_    - synchronous active-low reset
//   isyn    - incoming sync pulse, nominally 1 cycle high every PERIOD cycles
//   iclr    - synchronous clear of oerrcnt (wins over a same-cycle increment)
//   olock   - high while locked (SYNC)
//   ophase  - phase 0..PERIOD-1, 0 in the cycle after the expected slot
//   osyn    - regenerated 1-cycle sync pulse while locked
//   oerr    - 1-cycle pulse per missing/misplaced pulse while locked
//   oerrcnt - saturating error count
module syn_rcv #(
  parameter int PERIOD  = 8,
  parameter int CNTW    = 3,
  parameter int LOCKTHR = 2,
  parameter int LOSTHR  = 3
) (
  input  logic            iclk38,
  input  logic            rst_,
  input  logic            isyn,
  input  logic            iclr,
  output logic            olock,
  output logic [CNTW-1:0] ophase,
  output logic            osyn,
  output logic            oerr,
  output logic [7:0]      oerrcnt
);

  localparam int GW = $clog2(LOCKTHR + 1);
  localparam int MW = $clog2(LOSTHR + 1);
  localparam logic [CNTW-1:0] LASTPH = CNTW'(PERIOD - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   goodcnt, goodcnt_nx, goodcnt_inc;
  logic [MW-1:0]   misscnt, misscnt_nx, misscnt_inc;
  logic [CNTW-1:0] phase_nx, phase_inc;
  logic            slot;
  logic            err_nx;

  // slot is the cycle in which the next pulse is expected
  assign slot        = (ophase == LASTPH);
  assign phase_inc   = slot ? '0 : ophase + CNTW'(1);
  assign goodcnt_inc = goodcnt + GW'(1);
  assign misscnt_inc = misscnt + MW'(1);

  always_comb begin
    state_nx   = state;
    phase_nx   = phase_inc;
    goodcnt_nx = goodcnt;
    misscnt_nx = misscnt;
    err_nx     = 1'b0;
    unique case (state)
      HUNT: begin
        phase_nx = '0;
        // the anchoring pulse puts phase 0 in the following cycle
        if (isyn) begin
          state_nx   = PRESYNC;
          goodcnt_nx = GW'(1);
        end
      end
      PRESYNC: begin
        if (isyn && slot) begin
          goodcnt_nx = goodcnt_inc;
          if (goodcnt_inc == GW'(LOCKTHR)) begin
            state_nx   = SYNC;
            misscnt_nx = '0;
          end
        end else if (isyn) begin
          // off-slot pulse before lock: restart the count from this pulse
          phase_nx   = '0;
          goodcnt_nx = GW'(1);
        end else if (slot) begin
          state_nx   = HUNT;
          goodcnt_nx = '0;
        end
      end
      SYNC: begin
        // missing (slot, no pulse) and misplaced (pulse, no slot) both count;
        // timing keeps flywheeling, a misplaced pulse never re-anchors
        if (isyn != slot) begin
          err_nx = 1'b1;
          if (misscnt_inc == MW'(LOSTHR)) begin
            state_nx   = HUNT;
            phase_nx   = '0;
            misscnt_nx = '0;
          end else begin
            misscnt_nx = misscnt_inc;
          end
        end else if (slot) begin
          misscnt_nx = '0;
        end
      end
      default: begin
        state_nx   = HUNT;
        phase_nx   = '0;
        goodcnt_nx = '0;
        misscnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge iclk38) begin
    if (!rst_) begin
      state   <= HUNT;
      ophase  <= '0;
      goodcnt <= '0;
      misscnt <= '0;
      olock   <= 1'b0;
      osyn    <= 1'b0;
      oerr    <= 1'b0;
      oerrcnt <= '0;
    end else begin
      state   <= state_nx;
      ophase  <= phase_nx;
      goodcnt <= goodcnt_nx;
      misscnt <= misscnt_nx;
      olock   <= (state_nx == SYNC);
      // the slot that loses lock regenerates nothing
      osyn    <= slot && (state_nx == SYNC);
      oerr    <= err_nx;
      // counts the registered oerr, so a clear in the oerr cycle wins
      if (iclr) begin
        oerrcnt <= '0;
      end else if (oerr && (oerrcnt != 8'hFF)) begin
        oerrcnt <= oerrcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_syn_rcv.sv
module tb_syn_rcv;

  localparam int P  = 8;
  localparam int LT = 2;
  localparam int LS = 3;

  logic       iclk38 = 1'b0;
  logic       rst_   = 1'b0;
  logic       isyn   = 1'b0;
  logic       iclr   = 1'b0;
  logic       olock;
  logic [2:0] ophase;
  logic       osyn;
  logic       oerr;
  logic [7:0] oerrcnt;

  syn_rcv #(.PERIOD(P), .CNTW(3), .LOCKTHR(LT), .LOSTHR(LS)) dut (
    .iclk38 (iclk38),
    .rst_   (rst_),
    .isyn   (isyn),
    .iclr   (iclr),
    .olock  (olock),
    .ophase (ophase),
    .osyn   (osyn),
    .oerr   (oerr),
    .oerrcnt(oerrcnt)
  );

  always #5 iclk38 = ~iclk38;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the phase is derived from the absolute cycle number of
  // the anchoring pulse, so slot = ((cycle - anchor) mod P == P-1).
  localparam int M_HUNT = 0, M_PRE = 1, M_SYNC = 2;
  int     m_mode = M_HUNT;
  longint cyc = 0, anchor = 0;
  int     m_good = 0, m_miss = 0;
  int     e_lock = 0, e_phase = 0, e_osyn = 0, e_err = 0, e_cnt = 0;

  task model_step(input bit r, input bit s, input bit c);
    bit slot;
    bit nerr;
    if (!r) begin
      m_mode = M_HUNT; m_good = 0; m_miss = 0;
      e_lock = 0; e_phase = 0; e_osyn = 0; e_err = 0; e_cnt = 0;
      cyc++;
      return;
    end
    slot = (m_mode != M_HUNT) && (((cyc - anchor) % P) == P - 1);
    nerr = 1'b0;
    if (m_mode == M_HUNT) begin
      if (s) begin m_mode = M_PRE; anchor = cyc + 1; m_good = 1; end
    end else if (m_mode == M_PRE) begin
      if (s && slot) begin
        m_good++;
        if (m_good == LT) begin m_mode = M_SYNC; m_miss = 0; end
      end else if (s) begin
        anchor = cyc + 1; m_good = 1;
      end else if (slot) begin
        m_mode = M_HUNT; m_good = 0;
      end
    end else begin
      if (s != slot) begin
        nerr = 1'b1;
        m_miss++;
        if (m_miss >= LS) begin m_mode = M_HUNT; m_miss = 0; end
      end else if (slot) begin
        m_miss = 0;
      end
    end
    if (c) e_cnt = 0;
    else if (e_err != 0 && e_cnt < 255) e_cnt++;
    e_err  = nerr;
    e_osyn = (slot && m_mode == M_SYNC) ? 1 : 0;
    e_lock = (m_mode == M_SYNC) ? 1 : 0;
    cyc++;
    e_phase = (m_mode == M_HUNT) ? 0 : int'((cyc - anchor) % P);
  endtask

  task tick(input bit r, input bit s, input bit c);
    rst_ = r; isyn = s; iclr = c;
    @(posedge iclk38);
    model_step(r, s, c);
    #1;
    chk("m_olock",   olock,   e_lock);
    chk("m_ophase",  ophase,  e_phase);
    chk("m_osyn",    osyn,    e_osyn);
    chk("m_oerr",    oerr,    e_err);
    chk("m_oerrcnt", oerrcnt, e_cnt);
  endtask

  task lock_up();
    for (int k = 0; k < LT; k++) begin
      tick(1, 1, 0);
      if (k < LT - 1) repeat (P - 1) tick(1, 0, 0);
    end
  endtask

  typedef struct {
    bit r; bit s; bit c;
    bit lk; int ph; bit sy; bit er; int cnt;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mkv(bit r, bit s, bit c, bit lk, int ph, bit sy, bit er, int cnt);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.lk = lk; v.ph = ph; v.sy = sy; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  int  src;
  bit  rs, rr, rc;

  initial begin
    // Acquisition: reset 2 cycles, pulses at t0, t0+8, t0+16
    //            r  s  c   lk ph sy er cnt
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 3, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 4, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 5, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 6, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 7, 0, 0, 0));
    vq.push_back(mkv(1, 1, 0, 1, 0, 1, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 2, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 3, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 4, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 5, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 6, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 7, 0, 0, 0));
    vq.push_back(mkv(1, 1, 0, 1, 0, 1, 0, 0));
    vq.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0));

    foreach (vq[i]) begin
      tick(vq[i].r, vq[i].s, vq[i].c);
      chk($sformatf("vec%0d_olock", i),   olock,   vq[i].lk);
      chk($sformatf("vec%0d_ophase", i),  ophase,  vq[i].ph);
      chk($sformatf("vec%0d_osyn", i),    osyn,    vq[i].sy);
      chk($sformatf("vec%0d_oerr", i),    oerr,    vq[i].er);
      chk($sformatf("vec%0d_oerrcnt", i), oerrcnt, vq[i].cnt);
    end

    // Misplaced pulse in PRESYNC re-anchors without error
    tick(0, 0, 0);
    tick(1, 1, 0);
    repeat (4) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("t2_reanchor_phase", ophase, 0);
    chk("t2_reanchor_lock", olock, 0);
    chk("t2_reanchor_err", oerr, 0);
    repeat (7) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("t2_lock", olock, 1);
    chk("t2_err", oerr, 0);

    // Flywheel through missing pulses, loss on the third
    tick(0, 0, 0);
    lock_up();
    for (int k = 0; k < LS; k++) begin
      repeat (P) tick(1, 0, 0);
      chk($sformatf("t3_oerr%0d", k), oerr, 1);
      chk($sformatf("t3_osyn%0d", k), osyn, (k < LS - 1) ? 1 : 0);
      chk($sformatf("t3_lock%0d", k), olock, (k < LS - 1) ? 1 : 0);
    end
    chk("t3_phase", ophase, 0);
    tick(1, 0, 0);
    chk("t3_errcnt", oerrcnt, 3);

    // Misplaced pulse in SYNC, then aligned pulses clear the miss count
    tick(0, 0, 0);
    lock_up();
    repeat (3) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("t4_oerr", oerr, 1);
    repeat (3) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("t4_lock", olock, 1);
    chk("t4_errcnt", oerrcnt, 1);
    repeat (2 * P) tick(1, 0, 0);
    chk("t4_still_locked", olock, 1);

    // Saturation and clear priority
    tick(0, 0, 0);
    lock_up();
    for (int k = 0; k < 265; k++) begin
      repeat (3) tick(1, 0, 0);
      tick(1, 1, 0);
      repeat (3) tick(1, 0, 0);
      tick(1, 1, 0);
    end
    tick(1, 0, 0);
    chk("t5_sat", oerrcnt, 255);
    chk("t5_lock", olock, 1);
    repeat (2) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("t5_oerr", oerr, 1);
    tick(1, 0, 1);
    chk("t5_clr", oerrcnt, 0);

    // Reset while locked at phase 4
    tick(0, 0, 0);
    lock_up();
    tick(1, 1, 0);
    repeat (3) tick(1, 0, 0);
    chk("t6_phase4", ophase, 4);
    tick(0, 0, 0);
    chk("t6_lock", olock, 0);
    chk("t6_phase", ophase, 0);
    chk("t6_osyn", osyn, 0);
    chk("t6_cnt", oerrcnt, 0);
    lock_up();
    chk("t6_relock", olock, 1);
    chk("t6_reosyn", osyn, 1);

    // Randomised traffic against the model
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      rs = ((src == 0) && ($urandom_range(9) != 0)) || ($urandom_range(29) == 0);
      rc = ($urandom_range(49) == 0);
      rr = ($urandom_range(599) != 0);
      tick(rr, rs, rc);
      src = (src == P - 1) ? 0 : src + 1;
      if ($urandom_range(299) == 0) src = $urandom_range(P - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
